// File: rtl/cmd_dispatch_fsm_pkg.sv
// Shared definitions for the command dispatcher: verb and response byte codes,
// the 4-bit state encoding exposed on state_out, and the transmit push payload.
package cmd_dispatch_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned NUM_CHAN_MAX = 8;

  // Verb bytes accepted as the first byte of a frame
  localparam logic [BYTE_W-1:0] VERB_PING   = 8'd2;
  localparam logic [BYTE_W-1:0] VERB_GO     = 8'd6;
  localparam logic [BYTE_W-1:0] VERB_STATUS = 8'd7;

  // Response bytes sent back over the transmitter
  localparam logic [BYTE_W-1:0] RSP_HELLO   = 8'd1;
  localparam logic [BYTE_W-1:0] RSP_DONE    = 8'd3;
  localparam logic [BYTE_W-1:0] RSP_ACK     = 8'd4;
  localparam logic [BYTE_W-1:0] RSP_PONG    = 8'd5;
  localparam logic [BYTE_W-1:0] RSP_NACK    = 8'd8;
  localparam logic [BYTE_W-1:0] RSP_TIMEOUT = 8'd9;

  typedef enum logic [3:0] {
    S_HELLO  = 4'd0,
    S_IDLE   = 4'd1,
    S_ARGS   = 4'd2,
    S_DECODE = 4'd3,
    S_START  = 4'd4,
    S_RUN    = 4'd5,
    S_TXWAIT = 4'd6
  } state_e;

  // One or two response bytes handed to the transmit queue in a single cycle
  typedef struct packed {
    logic              push;
    logic              two;
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
  } tx_push_t;

endpackage

// File: rtl/cmd_dispatch_fsm_if.sv
// Bundle of receiver, transmitter and dispenser-channel signals.
//   master : dispatcher side (drives tx_*, disp_start/count, state_out)
//   slave  : environment side (drives rx_*, tx_busy, disp_done)
interface cmd_dispatch_fsm_if
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 3
);
  logic [BYTE_W-1:0]          rx_data;
  logic                       rx_valid;
  logic                       tx_busy;
  logic                       tx_start;
  logic [BYTE_W-1:0]          tx_data;
  logic                       disp_start;
  logic [NUM_CHAN*BYTE_W-1:0] disp_count;
  logic [NUM_CHAN-1:0]        disp_done;
  logic [3:0]                 state_out;

  modport master (
    input  rx_data, rx_valid, tx_busy, disp_done,
    output tx_start, tx_data, disp_start, disp_count, state_out
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, disp_done,
    input  tx_start, tx_data, disp_start, disp_count, state_out
  );
endinterface

// File: rtl/cmd_dispatch_fsm_tx_byte_queue.sv
// Two-entry response byte queue with the start/busy transmit handshake.
//   clk, rst_n      : clock, async active-low reset
//   push_i          : one or two bytes to queue (only issued while empty)
//   tx_busy_i       : transmitter busy level
//   tx_start_o      : one-cycle transmit request (registered)
//   tx_data_o       : byte sent, valid with tx_start_o (registered)
//   queue_idle_c_o  : nothing queued, nothing in flight (combinational)
module tx_byte_queue
  import cmd_dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  tx_push_t          push_i,
  input  logic              tx_busy_i,
  output logic              tx_start_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              queue_idle_c_o
);

  logic [BYTE_W-1:0] head_q, head_d;
  logic [BYTE_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              launch_c;

  // The transmitter may only raise busy the cycle after a start, so the start
  // cycle itself is never used to judge busy.
  assign launch_c       = (cnt_q != 2'd0) && !tx_busy_i && !tx_start_q;
  assign queue_idle_c_o = (cnt_q == 2'd0) && !tx_busy_i && !tx_start_q;
  assign tx_start_o     = tx_start_q;
  assign tx_data_o      = tx_data_q;

  // Load on push, shift out on launch
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (push_i.push) begin
      head_d = push_i.b0;
      tail_d = push_i.b1;
      cnt_d  = push_i.two ? 2'd2 : 2'd1;
    end else if (launch_c) begin
      tx_start_d = 1'b1;
      tx_data_d  = head_q;
      head_d     = tail_q;
      cnt_d      = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: rtl/cmd_dispatch_fsm.sv
// Byte-stream command sequencer: assembles verb + NUM_CHAN argument frames,
// starts the dispenser channels, waits for completion and answers via the
// transmit queue.
//   clk50m : system clock
//   reset  : async active-low reset
//   bus    : receiver / transmitter / dispenser signals (master side)
module cmd_dispatch_fsm
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CHAN     = 3,
  parameter logic [23:0] BYTE_TIMEOUT = 24'd5_000_000,
  parameter logic [31:0] RUN_TIMEOUT  = 32'd500_000_000
) (
  input logic               clk50m,
  input logic               reset,
  cmd_dispatch_fsm_if.master bus
);

  localparam int unsigned ARG_W = NUM_CHAN * BYTE_W;
  localparam int unsigned IDX_W = $clog2(NUM_CHAN_MAX + 1);
  localparam int unsigned GAP_W = 24;
  localparam int unsigned RUN_W = 32;

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [BYTE_W-1:0]  verb_q, verb_d;
  logic [ARG_W-1:0]   args_q, args_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               disp_start_q, disp_start_d;
  logic [ARG_W-1:0]   disp_count_q, disp_count_d;
  tx_push_t           push_c;
  logic               queue_idle_c;

  tx_byte_queue u_txq (
    .clk            (clk50m),
    .rst_n          (reset),
    .push_i         (push_c),
    .tx_busy_i      (bus.tx_busy),
    .tx_start_o     (bus.tx_start),
    .tx_data_o      (bus.tx_data),
    .queue_idle_c_o (queue_idle_c)
  );

  assign bus.disp_start = disp_start_q;
  assign bus.disp_count = disp_count_q;
  assign bus.state_out  = state_q;

  // Next-state, frame assembly, run supervision and response queuing
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    verb_d       = verb_q;
    args_d       = args_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    run_d        = run_q;
    disp_start_d = 1'b0;
    disp_count_d = disp_count_q;
    push_c       = '0;

    case (state_q)
      S_HELLO: begin
        push_c.push = 1'b1;
        push_c.b0   = RSP_HELLO;
        ret_d       = S_IDLE;
        state_d     = S_TXWAIT;
      end

      S_IDLE: begin
        if (bus.rx_valid) begin
          verb_d  = bus.rx_data;
          idx_d   = '0;
          gap_d   = '0;
          state_d = S_ARGS;
        end
      end

      // A byte arriving in the expiry cycle takes priority over the timeout
      S_ARGS: begin
        if (bus.rx_valid) begin
          for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (idx_q == IDX_W'(i)) args_d[i*BYTE_W +: BYTE_W] = bus.rx_data;
          end
          idx_d = idx_q + IDX_W'(1);
          gap_d = '0;
          if (idx_q == IDX_W'(NUM_CHAN - 1)) state_d = S_DECODE;
        end else if ((BYTE_TIMEOUT != '0) && (gap_q >= BYTE_TIMEOUT)) begin
          push_c.push = 1'b1;
          push_c.b0   = RSP_NACK;
          ret_d       = S_IDLE;
          state_d     = S_TXWAIT;
        end else if (gap_q != '1) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_DECODE: begin
        push_c.push = 1'b1;
        ret_d       = S_IDLE;
        state_d     = S_TXWAIT;
        case (verb_q)
          VERB_PING: push_c.b0 = RSP_PONG;
          VERB_STATUS: begin
            push_c.two = 1'b1;
            push_c.b0  = RSP_PONG;
            push_c.b1  = BYTE_W'(bus.disp_done);
          end
          VERB_GO: begin
            push_c.b0 = RSP_ACK;
            if (args_q == '0) begin
              push_c.two = 1'b1;
              push_c.b1  = RSP_DONE;
            end else begin
              ret_d = S_START;
            end
          end
          default: push_c.b0 = RSP_NACK;
        endcase
      end

      S_START: begin
        disp_count_d = args_q;
        disp_start_d = 1'b1;
        run_d        = '0;
        state_d      = S_RUN;
      end

      // Done levels may still reflect the previous run for two cycles
      S_RUN: begin
        if ((run_q >= RUN_W'(2)) && (&bus.disp_done)) begin
          push_c.push = 1'b1;
          push_c.b0   = RSP_DONE;
          ret_d       = S_IDLE;
          state_d     = S_TXWAIT;
        end else if ((RUN_TIMEOUT != '0) && (run_q >= RUN_TIMEOUT)) begin
          push_c.push = 1'b1;
          push_c.b0   = RSP_TIMEOUT;
          ret_d       = S_IDLE;
          state_d     = S_TXWAIT;
        end else if (run_q != '1) begin
          run_d = run_q + RUN_W'(1);
        end
      end

      S_TXWAIT: begin
        if (queue_idle_c) state_d = ret_q;
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) disp_count_d = '0;
  end

  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HELLO;
      ret_q        <= S_IDLE;
      verb_q       <= '0;
      args_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      run_q        <= '0;
      disp_start_q <= 1'b0;
      disp_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      verb_q       <= verb_d;
      args_q       <= args_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      run_q        <= run_d;
      disp_start_q <= disp_start_d;
      disp_count_q <= disp_count_d;
    end
  end

endmodule
